// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-level AXI-Stream arbiter.
package axis_arb_pkg;

   // Upper bound on source count; sizes the rotating-priority search.
   localparam int unsigned MAX_SRC  = 8;
   localparam int unsigned MAX_ID_W = 3;

   typedef enum logic [1:0] {
      StIdle,
      StPass,
      StDrain
   } arb_state_e;

   // First set bit of req at or above ptr, wrapping modulo n.
   function automatic logic [MAX_ID_W-1:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                                   input logic [MAX_ID_W-1:0] ptr,
                                                   input int unsigned n);
      logic [MAX_ID_W-1:0] pick;
      logic                done;
      int unsigned         idx;
      pick = '0;
      done = 1'b0;
      for (int unsigned off = 0; off < MAX_SRC; off++) begin
         idx = (32'(ptr) + off) % n;
         if (!done && (off < n) && req[idx[MAX_ID_W-1:0]]) begin
            pick = idx[MAX_ID_W-1:0];
            done = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: lowest requester at or above ptr.
module rr_arbiter
   import axis_arb_pkg::*;
#(
   parameter int unsigned N_SRC = 4
) (
   input  logic [N_SRC-1:0]                              req,
   input  logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] ptr,
   output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] idx,
   output logic                                          found
);

   localparam int unsigned ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   logic [MAX_SRC-1:0]  req_ext;
   logic [MAX_ID_W-1:0] ptr_ext;
   logic [MAX_ID_W-1:0] pick;

   // Widen to the package search width, search, then narrow back.
   always_comb begin
      req_ext = MAX_SRC'(req);
      ptr_ext = MAX_ID_W'(ptr);
      pick    = rr_pick(req_ext, ptr_ext, N_SRC);
      idx     = ID_W'(pick);
      found   = |req;
   end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter: N_SRC byte-wide AXI-Stream sources onto one sink.
// A grant is held from first byte to the tlast handshake; one idle bubble per frame.
// Optional length limit with truncation and drain: define AXIS_ARB_MAXLEN_EN.
module axis_pkt_arbiter
   import axis_arb_pkg::*;
#(
   parameter int unsigned N_SRC     = 4,
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned MAX_BYTES = 1518
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_SRC*8-1:0]       s_axis_tdata,
   input  logic [N_SRC-1:0]         s_axis_tvalid,
   output logic [N_SRC-1:0]         s_axis_tready,
   input  logic [N_SRC-1:0]         s_axis_tlast,
   output logic [7:0]               m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic [$clog2(N_SRC)-1:0] grant_id,
   output logic                     busy,
   output logic [CNT_W-1:0]         frames_out,
   output logic [CNT_W-1:0]         bytes_out,
   output logic                     trunc_err
);

   localparam int unsigned ID_W = $clog2(N_SRC);

   if (N_SRC < 2 || N_SRC > MAX_SRC || MAX_BYTES < 2) begin : g_param_chk
      $error("axis_pkt_arbiter: N_SRC must be 2..8 and MAX_BYTES at least 2");
   end

   arb_state_e       state_q;
   logic [ID_W-1:0]  grant_q;
   logic [ID_W-1:0]  rr_ptr_q;
   logic [ID_W-1:0]  pick_idx;
   logic [ID_W-1:0]  next_ptr;
   logic             pick_found;
   logic             busy_q;
   logic [CNT_W-1:0] frames_q;
   logic [CNT_W-1:0] bytes_q;
   logic             src_valid;
   logic             src_last;
   logic             sink_hs;
   logic             to_drain;

   rr_arbiter #(
      .N_SRC(N_SRC)
   ) u_rr_arbiter (
      .req  (s_axis_tvalid),
      .ptr  (rr_ptr_q),
      .idx  (pick_idx),
      .found(pick_found)
   );

`ifdef AXIS_ARB_MAXLEN_EN
   localparam int unsigned LEN_W = $clog2(MAX_BYTES + 1);

   logic [LEN_W-1:0] len_q;
   logic             at_limit;

   // The next handshake in PASS is the MAX_BYTES-th byte of this frame.
   always_comb begin
      at_limit  = (state_q == StPass) && (len_q == LEN_W'(MAX_BYTES - 1));
      trunc_err = sink_hs && at_limit && !src_last;
      to_drain  = trunc_err;
   end
`else
   assign trunc_err = 1'b0;
   assign to_drain  = 1'b0;
`endif

   assign next_ptr   = (grant_q == ID_W'(N_SRC - 1)) ? '0 : grant_q + 1'b1;
   assign grant_id   = grant_q;
   assign busy       = busy_q;
   assign frames_out = frames_q;
   assign bytes_out  = bytes_q;

   // Zero-latency mux from the granted source to the sink; readies follow the state.
   always_comb begin
      src_valid     = s_axis_tvalid[grant_q];
      src_last      = s_axis_tlast[grant_q];
      m_axis_tdata  = s_axis_tdata[{grant_q, 3'b000} +: 8];
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      case (state_q)
         StPass: begin
            m_axis_tvalid          = src_valid;
`ifdef AXIS_ARB_MAXLEN_EN
            m_axis_tlast           = src_last | at_limit;
`else
            m_axis_tlast           = src_last;
`endif
            s_axis_tready[grant_q] = m_axis_tready;
         end
`ifdef AXIS_ARB_MAXLEN_EN
         StDrain: s_axis_tready[grant_q] = 1'b1;
`endif
         default: ;
      endcase
      sink_hs = m_axis_tvalid && m_axis_tready;
   end

   // Arbitration FSM with registered grant, busy flag and statistics counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         busy_q   <= 1'b0;
         frames_q <= '0;
         bytes_q  <= '0;
`ifdef AXIS_ARB_MAXLEN_EN
         len_q    <= '0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (pick_found) begin
                  grant_q <= pick_idx;
                  busy_q  <= 1'b1;
                  state_q <= StPass;
`ifdef AXIS_ARB_MAXLEN_EN
                  len_q   <= '0;
`endif
               end
            end
            StPass: begin
               if (sink_hs) begin
                  bytes_q <= bytes_q + 1'b1;
`ifdef AXIS_ARB_MAXLEN_EN
                  len_q   <= len_q + 1'b1;
`endif
                  if (m_axis_tlast) begin
                     frames_q <= frames_q + 1'b1;
                     // A truncated frame keeps its grant until the source's own tlast.
                     if (to_drain) begin
                        state_q <= StDrain;
                     end else begin
                        rr_ptr_q <= next_ptr;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                     end
                  end
               end
            end
`ifdef AXIS_ARB_MAXLEN_EN
            StDrain: begin
               if (src_valid && src_last) begin
                  rr_ptr_q <= next_ptr;
                  busy_q   <= 1'b0;
                  state_q  <= StIdle;
               end
            end
`endif
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed, scoreboard-checked bench for axis_pkt_arbiter (4 sources).
module tb_axis_pkt_arbiter;

   localparam int N = 4;
`ifdef AXIS_ARB_MAXLEN_EN
   localparam int MAXB  = 64;
   localparam int LEN3  = 60;
`else
   localparam int MAXB  = 1518;
   localparam int LEN3  = 100;
`endif

   logic           clk;
   logic           rst_n;
   logic [N*8-1:0] s_axis_tdata;
   logic [N-1:0]   s_axis_tvalid;
   logic [N-1:0]   s_axis_tready;
   logic [N-1:0]   s_axis_tlast;
   logic [7:0]     m_axis_tdata;
   logic           m_axis_tvalid;
   logic           m_axis_tready;
   logic           m_axis_tlast;
   logic [1:0]     grant_id;
   logic           busy;
   logic [31:0]    frames_out;
   logic [31:0]    bytes_out;
   logic           trunc_err;

   axis_pkt_arbiter #(
      .N_SRC    (N),
      .CNT_W    (32),
      .MAX_BYTES(MAXB)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .s_axis_tlast (s_axis_tlast),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast),
      .grant_id     (grant_id),
      .busy         (busy),
      .frames_out   (frames_out),
      .bytes_out    (bytes_out),
      .trunc_err    (trunc_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-source byte queues {last,data} and sink scoreboard {src,last,data}.
   logic [8:0]  src_q [N][$];
   logic [11:0] sb [$];
   logic [N-1:0] stall;
   logic [N-1:0] hs;
   logic [N-1:0] ready_or;
   logic        rand_rdy;
   logic        gap_en, gap_armed, frame_start;
   int          cyc, last_tl_cyc, trunc_cnt, drain_cnt;
   int          total, bad;
   int unsigned exp_frames, exp_bytes;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Queue a frame at a source and the bytes the sink should see from it.
   task automatic push_frame(input int src, input int len, input int seed);
      int       exp_len;
      logic [7:0] d;
      exp_len = (len > MAXB) ? MAXB : len;
      for (int k = 0; k < len; k++) begin
         d = 8'(seed + k * 7);
         src_q[src].push_back({(k == len - 1), d});
         if (k < exp_len) sb.push_back({3'(src), (k == exp_len - 1), d});
      end
      exp_frames++;
      exp_bytes += exp_len;
   endtask

   function automatic logic all_done();
      logic e;
      e = (sb.size() == 0) && !busy;
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic wait_done(input string tag);
      int n;
      for (n = 0; n < 3000; n++) begin
         @(posedge clk);
         #3;
         if (all_done()) break;
      end
      check(tag, 32'(n < 3000), 32'd1);
   endtask

   task automatic wait_bytes(input int unsigned target);
      int n;
      for (n = 0; n < 3000; n++) begin
         @(posedge clk);
         #3;
         if (bytes_out >= target) break;
      end
      check("tmo_bytes", 32'(n < 3000), 32'd1);
   endtask

   // Source/sink driver and sink monitor: sample at negedge, drive 1ns after posedge.
   initial begin : bfm
      logic [11:0] e;
      logic [8:0]  b;
      forever begin
         @(negedge clk);
         cyc++;
         hs = rst_n ? (s_axis_tvalid & s_axis_tready) : '0;
         if (rst_n) ready_or |= s_axis_tready;
         if (rst_n && trunc_err) trunc_cnt++;
         if (rst_n && !m_axis_tvalid && (hs != '0)) drain_cnt++;
         if (rst_n && m_axis_tvalid && m_axis_tready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("sink_data", 32'(m_axis_tdata), 32'(e[7:0]));
               check("sink_last", 32'(m_axis_tlast), 32'(e[8]));
               check("sink_grant", 32'(grant_id), 32'(e[11:9]));
            end
            if (gap_en && frame_start && gap_armed) check("gap", 32'(cyc - last_tl_cyc), 32'd2);
            frame_start = m_axis_tlast;
            if (m_axis_tlast) begin
               last_tl_cyc = cyc;
               gap_armed   = 1'b1;
            end
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (hs[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            if (src_q[i].size() != 0 && !stall[i]) begin
               b                   = src_q[i][0];
               s_axis_tvalid[i]    = 1'b1;
               s_axis_tlast[i]     = b[8];
               s_axis_tdata[i*8 +: 8] = b[7:0];
            end else begin
               s_axis_tvalid[i] = 1'b0;
               s_axis_tlast[i]  = 1'b0;
            end
         end
         m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin : main
      int unsigned base;
      total = 0; bad = 0; cyc = 0; trunc_cnt = 0; drain_cnt = 0;
      exp_frames = 0; exp_bytes = 0;
      stall = '0; ready_or = '0; rand_rdy = 1'b0;
      gap_en = 1'b0; gap_armed = 1'b0; frame_start = 1'b1; last_tl_cyc = 0;
      s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0; m_axis_tready = 1'b1;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check("rst_grant", 32'(grant_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frames", frames_out, 32'd0);
      check("rst_bytes", bytes_out, 32'd0);
      check("rst_trunc", 32'(trunc_err), 32'd0);
      check("rst_sready", 32'(s_axis_tready), 32'd0);
      check("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #3;

      // Single 64-byte frame from source 2.
      push_frame(2, 64, 8'h10);
      @(posedge clk); #3;
      check("t1_tvalid", 32'(s_axis_tvalid[2]), 32'd1);
      check("t1_busy_pre", 32'(busy), 32'd0);
      @(posedge clk); #3;
      check("t1_grant", 32'(grant_id), 32'd2);
      check("t1_busy", 32'(busy), 32'd1);
      wait_done("t1_done");
      check("t1_frames", frames_out, 32'd1);
      check("t1_bytes", bytes_out, 32'd64);
      check("t1_busy_end", 32'(busy), 32'd0);

      // One-byte frame from source 3 moves the pointer to 0.
      push_frame(3, 1, 8'hA5);
      wait_done("t1b_done");
      check("t1b_frames", frames_out, exp_frames);

      // All four sources offering 16-byte frames: 0,1,2,3,0,1 with one bubble each.
      gap_armed = 1'b0; gap_en = 1'b1;
      push_frame(0, 16, 8'h00);
      push_frame(1, 16, 8'h40);
      push_frame(2, 16, 8'h80);
      push_frame(3, 16, 8'hC0);
      push_frame(0, 16, 8'h21);
      push_frame(1, 16, 8'h61);
      wait_done("t2_done");
      gap_en = 1'b0;
      check("t2_frames", frames_out, exp_frames);
      check("t2_bytes", bytes_out, exp_bytes);

      // Random sink backpressure on a long frame from source 1.
      ready_or = '0; rand_rdy = 1'b1;
      push_frame(1, LEN3, 8'h33);
      wait_done("t3_done");
      rand_rdy = 1'b0;
      check("t3_readies", 32'(ready_or), 32'b0010);
      check("t3_bytes", bytes_out, exp_bytes);

      // Source 0 stalls mid-frame while source 3 requests.
      base = exp_bytes;
      push_frame(0, 40, 8'h05);
      wait_bytes(base + 10);
      stall[0] = 1'b1;
      push_frame(3, 8, 8'hE0);
      repeat (20) @(posedge clk);
      #3;
      check("t4_grant_hold", 32'(grant_id), 32'd0);
      check("t4_busy_hold", 32'(busy), 32'd1);
      check("t4_no_ready3", 32'(s_axis_tready[3]), 32'd0);
      stall[0] = 1'b0;
      wait_done("t4_done");
      check("t4_frames", frames_out, exp_frames);

      // Reset at byte 30 of a 64-byte frame; pointer was 3 before it.
      push_frame(2, 1, 8'h77);
      wait_done("t5_pre");
      base = exp_bytes;
      push_frame(1, 64, 8'h90);
      wait_bytes(base + 30);
      rst_n = 1'b0;
      #1;
      check("t5_sready", 32'(s_axis_tready), 32'd0);
      check("t5_mvalid", 32'(m_axis_tvalid), 32'd0);
      check("t5_frames", frames_out, 32'd0);
      check("t5_bytes", bytes_out, 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      for (int i = 0; i < N; i++) src_q[i].delete();
      sb.delete();
      frame_start = 1'b1;
      exp_frames = 0; exp_bytes = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #3;
      push_frame(1, 10, 8'h11);
      push_frame(3, 10, 8'h55);
      wait_done("t5_done");
      check("t5_frames_after", frames_out, 32'd2);
      check("t5_bytes_after", bytes_out, 32'd20);

`ifdef AXIS_ARB_MAXLEN_EN
      // Oversize frame: forced tlast on byte 64, one trunc pulse, 6 bytes drained.
      trunc_cnt = 0; drain_cnt = 0;
      base = exp_bytes;
      push_frame(0, 70, 8'h02);
      wait_done("t6_done");
      check("t6_trunc", 32'(trunc_cnt), 32'd1);
      check("t6_drain", 32'(drain_cnt), 32'd6);
      check("t6_bytes", bytes_out, base + 64);
      check("t6_frames", frames_out, exp_frames);
      push_frame(2, 64, 8'h44);
      wait_done("t6b_done");
      check("t6b_trunc", 32'(trunc_cnt), 32'd1);
      check("t6b_frames", frames_out, exp_frames);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
